// File: rtl/vga_pkg.sv
// Shared constants for the rectangle-fill bus master:
// register addresses, screen limits and FSM encoding.
package vga_pkg;

  localparam logic [7:0] VGA_COL_ADDR = 8'hB0;
  localparam logic [7:0] VGA_X_ADDR   = 8'hB1;
  localparam logic [7:0] VGA_Y_ADDR   = 8'hB2;

  localparam logic [7:0] X_MAX = 8'd159;
  localparam logic [6:0] Y_MAX = 7'd119;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE = 3'd0;
  localparam state_t S_COL  = 3'd1;
  localparam state_t S_ROW  = 3'd2;
  localparam state_t S_PIX  = 3'd3;
  localparam state_t S_FIN  = 3'd4;

endpackage

// File: rtl/rect_scan_counter.sv
// Row/column scan counters over a latched inclusive
// rectangle, with last-column / last-row flags.
module rect_scan_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       step,
  input  logic [7:0] x0,
  input  logic [7:0] x1,
  input  logic [6:0] y0,
  input  logic [6:0] y1,
  output logic [7:0] col,
  output logic [6:0] row,
  output logic       col_last,
  output logic       row_last
);

  logic [7:0] x0_q;
  logic [7:0] x1_q;
  logic [6:0] y1_q;

  assign col_last = (col == x1_q);
  assign row_last = (row == y1_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
      col  <= '0;
      row  <= '0;
    end else if (load) begin
      x0_q <= x0;
      x1_q <= x1;
      y1_q <= y1;
      col  <= x0;
      row  <= y0;
    end else if (step) begin
      if (col_last) begin
        col <= x0_q;
        if (!row_last)
          row <= row + 7'd1;
      end else begin
        col <= col + 8'd1;
      end
    end
  end

endmodule

// File: rtl/vga_rect_fill.sv
// Bus master that paints a solid rectangle by writing
// colour, Y and X registers of a VGA frame buffer.
module vga_rect_fill #(
  parameter logic [7:0] VGA_COL_ADDR = vga_pkg::VGA_COL_ADDR,
  parameter logic [7:0] VGA_X_ADDR   = vga_pkg::VGA_X_ADDR,
  parameter logic [7:0] VGA_Y_ADDR   = vga_pkg::VGA_Y_ADDR,
  parameter logic [7:0] X_MAX        = vga_pkg::X_MAX,
  parameter logic [6:0] Y_MAX        = vga_pkg::Y_MAX
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START,
  input  logic [7:0] X0,
  input  logic [7:0] X1,
  input  logic [6:0] Y0,
  input  logic [6:0] Y1,
  input  logic [7:0] COLOUR,
  input  logic       COL_EN,
  input  logic       ABORT,
  input  logic       BUS_GNT,
  output logic       BUS_REQ,
  output logic [7:0] BUS_ADDR,
  output logic [7:0] BUS_DATA,
  output logic       BUS_WE,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR
);

  import vga_pkg::*;

  state_t     state;
  logic [7:0] colour_q;
  logic [7:0] col;
  logic [6:0] row;
  logic       col_last;
  logic       row_last;
  logic       bad;
  logic       active;
  logic       last_wr;
  logic       abort_now;
  logic       load;
  logic       step;

  assign bad = (X0 > X1) || (Y0 > Y1) ||
               (X1 > X_MAX) || (Y1 > Y_MAX);

  assign active = (state == S_COL) ||
                  (state == S_ROW) ||
                  (state == S_PIX);

  // A granted final pixel wins over a simultaneous abort.
  assign last_wr = (state == S_PIX) && BUS_GNT &&
                   col_last && row_last;

  assign abort_now = active && ABORT && !last_wr;
  assign load = (state == S_IDLE) && START && !bad;
  assign step = (state == S_PIX) && BUS_GNT && !abort_now;

  rect_scan_counter u_scan (
    .clk      (CLK),
    .rst_n    (RESET),
    .load     (load),
    .step     (step),
    .x0       (X0),
    .x1       (X1),
    .y0       (Y0),
    .y1       (Y1),
    .col      (col),
    .row      (row),
    .col_last (col_last),
    .row_last (row_last)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= S_IDLE;
      colour_q <= '0;
      BUS_REQ  <= 1'b0;
      BUS_ADDR <= '0;
      BUS_DATA <= '0;
      BUS_WE   <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      BUS_WE   <= 1'b0;
      BUS_ADDR <= '0;
      BUS_DATA <= '0;
      DONE     <= 1'b0;
      ERR      <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (START) begin
            if (bad) begin
              DONE <= 1'b1;
              ERR  <= 1'b1;
            end else begin
              colour_q <= COLOUR;
              BUSY     <= 1'b1;
              BUS_REQ  <= 1'b1;
              state    <= COL_EN ? S_COL : S_ROW;
            end
          end
        end
        S_COL, S_ROW, S_PIX: begin
          if (abort_now) begin
            state   <= S_IDLE;
            BUSY    <= 1'b0;
            BUS_REQ <= 1'b0;
            DONE    <= 1'b1;
            ERR     <= 1'b1;
          end else if (BUS_GNT) begin
            BUS_WE <= 1'b1;
            unique case (1'b1)
              state == S_COL: begin
                BUS_ADDR <= VGA_COL_ADDR;
                BUS_DATA <= colour_q;
                state    <= S_ROW;
              end
              state == S_ROW: begin
                BUS_ADDR <= VGA_Y_ADDR;
                BUS_DATA <= {1'b0, row};
                state    <= S_PIX;
              end
              default: begin
                BUS_ADDR <= VGA_X_ADDR;
                BUS_DATA <= col;
                if (col_last)
                  state <= row_last ? S_FIN : S_ROW;
              end
            endcase
          end
        end
        S_FIN: begin
          state   <= S_IDLE;
          BUSY    <= 1'b0;
          BUS_REQ <= 1'b0;
          DONE    <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vga_rect_fill.sv
// Directed bench for vga_rect_fill: fill, reject, grant
// toggling, abort and mid-job reset scenarios.
module tb_vga_rect_fill;

  logic       CLK;
  logic       RESET;
  logic       START;
  logic [7:0] X0;
  logic [7:0] X1;
  logic [6:0] Y0;
  logic [6:0] Y1;
  logic [7:0] COLOUR;
  logic       COL_EN;
  logic       ABORT;
  logic       BUS_GNT;
  logic       BUS_REQ;
  logic [7:0] BUS_ADDR;
  logic [7:0] BUS_DATA;
  logic       BUS_WE;
  logic       BUSY;
  logic       DONE;
  logic       ERR;

  int nchk = 0;
  int npass = 0;
  int nwr = 0;
  int bad_wr = 0;
  int req_hi = 0;
  int done_cnt = 0;
  int cyc = 0;
  logic gnt_q = 1'b0;
  logic [15:0] wlog [0:63];
  int wcyc [0:63];

  logic [15:0] exp_fill [0:8] = '{
    16'hB03C, 16'hB20A, 16'hB102, 16'hB103, 16'hB104,
    16'hB20B, 16'hB102, 16'hB103, 16'hB104
  };

  vga_rect_fill dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .START    (START),
    .X0       (X0),
    .X1       (X1),
    .Y0       (Y0),
    .Y1       (Y1),
    .COLOUR   (COLOUR),
    .COL_EN   (COL_EN),
    .ABORT    (ABORT),
    .BUS_GNT  (BUS_GNT),
    .BUS_REQ  (BUS_REQ),
    .BUS_ADDR (BUS_ADDR),
    .BUS_DATA (BUS_DATA),
    .BUS_WE   (BUS_WE),
    .BUSY     (BUSY),
    .DONE     (DONE),
    .ERR      (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) gnt_q <= BUS_GNT;

  always @(negedge CLK) begin
    cyc = cyc + 1;
    if (BUS_WE) begin
      if (nwr < 64) begin
        wlog[nwr] = {BUS_ADDR, BUS_DATA};
        wcyc[nwr] = cyc;
      end
      nwr = nwr + 1;
      if (!gnt_q) bad_wr = bad_wr + 1;
    end
    if (BUS_REQ) req_hi = req_hi + 1;
    if (DONE) done_cnt = done_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got === exp) npass++;
    else $display("FAIL %s got %0h want %0h", tag, got, exp);
  endtask

  task automatic tick;
    @(negedge CLK);
    #1;
  endtask

  task automatic start_job(input logic [7:0] x0,
                           input logic [7:0] x1,
                           input logic [6:0] y0,
                           input logic [6:0] y1,
                           input logic [7:0] c,
                           input logic ce,
                           input logic g);
    nwr = 0;
    bad_wr = 0;
    req_hi = 0;
    done_cnt = 0;
    X0 = x0;
    X1 = x1;
    Y0 = y0;
    Y1 = y1;
    COLOUR = c;
    COL_EN = ce;
    BUS_GNT = g;
    START = 1'b1;
    tick();
    START = 1'b0;
    X0 = 8'hEE;
    X1 = 8'h00;
    Y0 = 7'h7F;
    Y1 = 7'h00;
    COLOUR = ~c;
    COL_EN = ~ce;
  endtask

  task automatic wait_done(input bit tog);
    int n = 0;
    while (!DONE && n < 300) begin
      if (tog) BUS_GNT = ~BUS_GNT;
      tick();
      n++;
    end
    chk("done_seen", {31'd0, DONE}, 1);
  endtask

  initial begin
    RESET = 1'b0;
    START = 1'b0;
    X0 = '0;
    X1 = '0;
    Y0 = '0;
    Y1 = '0;
    COLOUR = '0;
    COL_EN = 1'b0;
    ABORT = 1'b0;
    BUS_GNT = 1'b0;
    repeat (2) tick();
    chk("rst_outs", {BUS_REQ, BUS_WE, BUSY, DONE, ERR,
                     BUS_ADDR, BUS_DATA}, 0);
    RESET = 1'b1;
    tick();

    start_job(8'd2, 8'd4, 7'd10, 7'd11, 8'h3C, 1'b1, 1'b1);
    chk("fill_busy", {30'd0, BUSY, BUS_REQ}, 3);
    wait_done(1'b0);
    chk("fill_err", {31'd0, ERR}, 0);
    chk("fill_busy_off", {30'd0, BUSY, BUS_REQ}, 0);
    chk("fill_nwr", nwr, 9);
    for (int i = 0; i < 9; i++)
      chk($sformatf("fill_w%0d", i), {16'd0, wlog[i]},
          {16'd0, exp_fill[i]});
    chk("fill_b2b", wcyc[8] - wcyc[0], 8);
    tick();
    chk("done_pulse", {31'd0, DONE}, 0);

    start_job(8'd5, 8'd4, 7'd0, 7'd0, 8'h11, 1'b1, 1'b1);
    chk("rejx_done", {30'd0, DONE, ERR}, 3);
    tick();
    chk("rejx_req", req_hi, 0);
    chk("rejx_nwr", nwr, 0);

    start_job(8'd0, 8'd3, 7'd0, 7'd120, 8'h22, 1'b1, 1'b1);
    chk("rejy_done", {30'd0, DONE, ERR}, 3);
    repeat (3) tick();
    chk("rejy_nwr", nwr, 0);

    start_job(8'd0, 8'd160, 7'd0, 7'd0, 8'h22, 1'b0, 1'b1);
    chk("rejxm_done", {30'd0, DONE, ERR}, 3);

    start_job(8'd7, 8'd7, 7'd3, 7'd3, 8'h55, 1'b0, 1'b0);
    wait_done(1'b1);
    chk("tog_err", {31'd0, ERR}, 0);
    chk("tog_nwr", nwr, 2);
    chk("tog_w0", {16'd0, wlog[0]}, 32'hB203);
    chk("tog_w1", {16'd0, wlog[1]}, 32'hB107);
    chk("tog_nognt", bad_wr, 0);
    BUS_GNT = 1'b1;

    start_job(8'd159, 8'd159, 7'd119, 7'd119,
              8'h01, 1'b0, 1'b1);
    wait_done(1'b0);
    chk("corner_err", {31'd0, ERR}, 0);
    chk("corner_nwr", nwr, 2);
    chk("corner_w0", {16'd0, wlog[0]}, 32'hB277);
    chk("corner_w1", {16'd0, wlog[1]}, 32'hB19F);

    start_job(8'd0, 8'd3, 7'd0, 7'd3, 8'h77, 1'b0, 1'b1);
    for (int n = 0; n < 50 && nwr < 3; n++) tick();
    chk("ab_reach", nwr, 3);
    ABORT = 1'b1;
    tick();
    chk("ab_done", {28'd0, DONE, ERR, BUSY, BUS_WE}, 32'hC);
    tick();
    chk("ab_idle", {31'd0, DONE}, 0);
    ABORT = 1'b0;
    repeat (3) tick();
    chk("ab_nwr", nwr, 3);
    chk("ab_w2", {16'd0, wlog[2]}, 32'hB101);

    start_job(8'd0, 8'd3, 7'd0, 7'd3, 8'h44, 1'b1, 1'b1);
    repeat (3) tick();
    RESET = 1'b0;
    #1;
    chk("rst_async", {BUS_REQ, BUS_WE, BUSY, DONE, ERR,
                      BUS_ADDR, BUS_DATA}, 0);
    repeat (2) tick();
    RESET = 1'b1;
    done_cnt = 0;
    repeat (10) tick();
    chk("rst_nodone", done_cnt, 0);

    start_job(8'd1, 8'd2, 7'd5, 7'd5, 8'h81, 1'b1, 1'b1);
    chk("rst_start", {31'd0, BUSY}, 1);
    wait_done(1'b0);
    chk("rst_err", {31'd0, ERR}, 0);
    chk("rst_nwr", nwr, 4);
    chk("rst_w0", {16'd0, wlog[0]}, 32'hB081);
    chk("rst_w3", {16'd0, wlog[3]}, 32'hB102);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
